word_scanner: RTL and testbench
===============================

Name: word_scanner

Overview:
Parametrised successor to the fixed four-letter word reader. It accepts a stream of SYM_W-bit symbols, one per clock when valid, split into words by a delimiter symbol. Each word is compared against up to NUM_WORDS runtime-programmable patterns of up to MAX_LEN symbols. It sits between the symbol deserialiser and the word-event logic, and reports a one-cycle match vector, an error pulse for unrecognised words, and a saturating count of recognised words.

Parameters:
SYM_W, 2, bits per symbol
MAX_LEN, 8, maximum symbols per pattern (excluding delimiter)
NUM_WORDS, 4, number of programmable pattern slots
DELIM, 0, symbol value that terminates a word (SYM_W bits)
CNT_W, 8, width of recognised-word counter

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
bits  in  SYM_W  input symbol
bits_valid  in  1  bits is sampled only when high
cfg_we  in  1  pattern write strobe
cfg_word  in  clog2(NUM_WORDS)  slot being written
cfg_pos  in  clog2(MAX_LEN)  symbol index within slot
cfg_sym  in  SYM_W  symbol value written at cfg_pos
cfg_len  in  clog2(MAX_LEN+1)  slot length, written together with the symbol
match  out  NUM_WORDS  one-hot/multi-hot slots matched by the word just closed
match_valid  out  1  one-cycle pulse, high when match is nonzero
error  out  1  one-cycle pulse when a non-empty word matched no slot
word_count  out  CNT_W  saturating count of match_valid pulses

Behaviour:
- Reset (clk edge with reset=1):
  - match=0, match_valid=0, error=0, word_count=0.
  - All slot lengths=0; pattern symbols=0.
  - FSM=IDLE, pos=0, alive mask=all ones.
  - reset has priority over every other input.
- Slot with length 0 is disabled and never matches. cfg_len values >MAX_LEN are clamped to MAX_LEN.
- FSM states:
  - IDLE: between words.
  - ACTIVE: collecting a word.
  - REJECT: word exceeded MAX_LEN or was aborted; discard until the delimiter.
- Cycles with bits_valid=0: no state change. Outputs still drop to 0 after their pulse cycle.
- IDLE:
  - Delimiter: stay in IDLE with no output; consecutive delimiters are ignored.
  - Non-delimiter symbol s: go to ACTIVE, pos=1, alive[w]=(len[w]>=1 && pat[w][0]==s).
- ACTIVE:
  - Non-delimiter s with pos<MAX_LEN: alive[w]&=(pos<len[w] && pat[w][pos]==s); pos++.
  - Non-delimiter with pos==MAX_LEN: go to REJECT.
  - Delimiter: m[w]=alive[w] && (pos==len[w]) for all w. Register match=m on the same edge, so match is visible the cycle after the delimiter is sampled (latency 1).
    - If m is nonzero: match_valid=1 and word_count increments, saturating at 2^CNT_W-1.
    - If m is zero: error=1.
    - FSM returns to IDLE, pos=0.
- REJECT: non-delimiter symbols are ignored. On a delimiter, error=1 (one cycle) and FSM returns to IDLE.
- Several slots may match the same word; all corresponding match bits are set together.
- Config writes:
  - An accepted write updates pat[cfg_word][cfg_pos] and len[cfg_word] on that edge.
  - A write while the FSM is ACTIVE forces REJECT on the same edge, so a pattern never changes under an in-flight word.
  - A write in IDLE or REJECT does not change FSM state.
  - If cfg_we coincides with a valid symbol, the config write wins and the symbol is processed as a REJECT-state symbol (a delimiter still closes the word with error=1).
  - Out-of-range cfg_word or cfg_pos is ignored.
- Reset during ACTIVE or REJECT discards the word and no pulse is emitted.

Test Plan:
Defaults throughout (SYM_W=2, MAX_LEN=8, NUM_WORDS=4, DELIM=00).
1. Reset, program slot0=[11,00? no: 11,01] (len 2). Stream 00,11,01,00 -> match=0001 and match_valid=1 for exactly one cycle after the final 00. word_count=1, error never asserted.
2. Program slot1=[11,01,10] (len 3) alongside slot0. Stream 11,01,10,00 -> match=0010. Stream 11,01,00 -> match=0001. Stream 11,10,00 -> error=1, match=0.
3. Program slot2=slot3=[10] (len 1). Stream 10,00 -> match=1100 and word_count increments by exactly 1.
4. Stream nine 11 symbols then 00 -> FSM reaches REJECT after the 9th symbol; a single error pulse after the delimiter; no match. Then 00,00,00 -> no outputs.
5. With CNT_W=2, send five matching words -> word_count reads 1,2,3,3,3.
6. Mid-word: stream 11, assert cfg_we with 01 valid, then 00 -> error=1, no match. Next word 11,01,00 -> match per updated patterns. Assert reset mid-word -> all outputs 0, no pulse on the following delimiter.

Source files
------------

// File: rtl/word_scanner.sv
// Splits a symbol stream into delimiter-terminated words and matches each against programmable patterns.
// Latency 1: match/match_valid/error pulse the cycle after the closing delimiter; no backpressure, bits_valid gates input.
module word_scanner #(
  parameter int               SYM_W     = 2,
  parameter int               MAX_LEN   = 8,
  parameter int               NUM_WORDS = 4,
  parameter logic [SYM_W-1:0] DELIM     = '0,
  parameter int               CNT_W     = 8,
  localparam int              WW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  localparam int              PW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
  localparam int              LW        = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SYM_W-1:0]     bits,
  input  logic                 bits_valid,
  input  logic                 cfg_we,
  input  logic [WW-1:0]        cfg_word,
  input  logic [PW-1:0]        cfg_pos,
  input  logic [SYM_W-1:0]     cfg_sym,
  input  logic [LW-1:0]        cfg_len,
  output logic [NUM_WORDS-1:0] match,
  output logic                 match_valid,
  output logic                 error,
  output logic [CNT_W-1:0]     word_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] REJECT = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [LW-1:0]        pos_q, pos_d;
  logic [NUM_WORDS-1:0] alive_q, alive_d;
  logic [SYM_W-1:0]     pat_q [NUM_WORDS][MAX_LEN];
  logic [SYM_W-1:0]     pat_d [NUM_WORDS][MAX_LEN];
  logic [LW-1:0]        len_q [NUM_WORDS];
  logic [LW-1:0]        len_d [NUM_WORDS];
  logic [NUM_WORDS-1:0] match_q, match_d;
  logic                 match_valid_q, match_valid_d;
  logic                 error_q, error_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 cfg_ok;
  logic                 is_delim;
  logic [1:0]           st;
  logic [NUM_WORDS-1:0] m_c;

  assign cfg_ok   = cfg_we && (int'(cfg_word) < NUM_WORDS) && (int'(cfg_pos) < MAX_LEN);
  assign is_delim = (bits == DELIM);

  always_comb begin
    state_d       = state_q;
    pos_d         = pos_q;
    alive_d       = alive_q;
    pat_d         = pat_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    match_d       = '0;
    match_valid_d = 1'b0;
    error_d       = 1'b0;
    m_c           = '0;

    if (cfg_ok) begin
      pat_d[cfg_word][cfg_pos] = cfg_sym;
      len_d[cfg_word] = (int'(cfg_len) > MAX_LEN) ? LW'(MAX_LEN) : cfg_len;
    end

    // A write under an in-flight word poisons it; the symbol on that edge is then a REJECT symbol.
    st      = (cfg_ok && state_q == ACTIVE) ? REJECT : state_q;
    state_d = st;

    // In IDLE a write-coincident symbol has no word to belong to, so it is dropped.
    if (bits_valid && !(cfg_ok && state_q == IDLE)) begin
      case (st)
        IDLE: begin
          if (!is_delim) begin
            state_d = ACTIVE;
            pos_d   = LW'(1);
            for (int w = 0; w < NUM_WORDS; w++)
              alive_d[w] = (len_q[w] != '0) && (pat_q[w][0] == bits);
          end
        end
        ACTIVE: begin
          if (is_delim) begin
            for (int w = 0; w < NUM_WORDS; w++)
              m_c[w] = alive_q[w] && (pos_q == len_q[w]);
            match_d = m_c;
            if (|m_c) begin
              match_valid_d = 1'b1;
              if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            end else begin
              error_d = 1'b1;
            end
            state_d = IDLE;
            pos_d   = '0;
            alive_d = '1;
          end else if (int'(pos_q) < MAX_LEN) begin
            for (int w = 0; w < NUM_WORDS; w++)
              alive_d[w] = alive_q[w] && (pos_q < len_q[w]) && (pat_q[w][pos_q[PW-1:0]] == bits);
            pos_d = pos_q + LW'(1);
          end else begin
            state_d = REJECT;
          end
        end
        default: begin
          if (is_delim) begin
            error_d = 1'b1;
            state_d = IDLE;
            pos_d   = '0;
            alive_d = '1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pos_q         <= '0;
      alive_q       <= '1;
      match_q       <= '0;
      match_valid_q <= 1'b0;
      error_q       <= 1'b0;
      cnt_q         <= '0;
      for (int w = 0; w < NUM_WORDS; w++) begin
        len_q[w] <= '0;
        for (int p = 0; p < MAX_LEN; p++) pat_q[w][p] <= '0;
      end
    end else begin
      state_q       <= state_d;
      pos_q         <= pos_d;
      alive_q       <= alive_d;
      match_q       <= match_d;
      match_valid_q <= match_valid_d;
      error_q       <= error_d;
      cnt_q         <= cnt_d;
      len_q         <= len_d;
      pat_q         <= pat_d;
    end
  end

  assign match       = match_q;
  assign match_valid = match_valid_q;
  assign error       = error_q;
  assign word_count  = cnt_q;

endmodule

// File: tb/tb_word_scanner.sv
// Directed bench for word_scanner: a default instance plus a CNT_W=2 instance sharing the same stimulus.
module tb_word_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] bits;
  logic       bits_valid;
  logic       cfg_we;
  logic [1:0] cfg_word;
  logic [2:0] cfg_pos;
  logic [1:0] cfg_sym;
  logic [3:0] cfg_len;
  logic [3:0] match, match2;
  logic       match_valid, mv2;
  logic       error, err2;
  logic [7:0] word_count;
  logic [1:0] wc2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  word_scanner dut (
    .clk(clk), .reset(reset), .bits(bits), .bits_valid(bits_valid),
    .cfg_we(cfg_we), .cfg_word(cfg_word), .cfg_pos(cfg_pos), .cfg_sym(cfg_sym), .cfg_len(cfg_len),
    .match(match), .match_valid(match_valid), .error(error), .word_count(word_count)
  );

  word_scanner #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .bits(bits), .bits_valid(bits_valid),
    .cfg_we(cfg_we), .cfg_word(cfg_word), .cfg_pos(cfg_pos), .cfg_sym(cfg_sym), .cfg_len(cfg_len),
    .match(match2), .match_valid(mv2), .error(err2), .word_count(wc2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int m, input int v, input int e, input int c);
    check({tag, ".match"}, 32'(match), m);
    check({tag, ".match_valid"}, 32'(match_valid), v);
    check({tag, ".error"}, 32'(error), e);
    check({tag, ".word_count"}, 32'(word_count), c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int s);
    bits       = 2'(s);
    bits_valid = 1'b1;
    tick();
    bits_valid = 1'b0;
    bits       = 2'd0;
  endtask

  task automatic prog(input int w, input int p, input int s, input int l);
    cfg_word = 2'(w);
    cfg_pos  = 3'(p);
    cfg_sym  = 2'(s);
    cfg_len  = 4'(l);
    cfg_we   = 1'b1;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; bits = 2'd0; bits_valid = 1'b0;
    cfg_we = 1'b0; cfg_word = 2'd0; cfg_pos = 3'd0; cfg_sym = 2'd0; cfg_len = 4'd0;
    do_reset();
    expect_out("reset", 0, 0, 0, 0);
    check("reset.cnt2", 32'(wc2), 0);

    // Slot0 = [11,01]; leading delimiter is ignored.
    prog(0, 0, 3, 2);
    prog(0, 1, 1, 2);
    send(0);
    expect_out("t1.lead_delim", 0, 0, 0, 0);
    send(3);
    send(1);
    expect_out("t1.mid", 0, 0, 0, 0);
    send(0);
    expect_out("t1.close", 1, 1, 0, 1);
    tick();
    expect_out("t1.drop", 0, 0, 0, 1);

    // Slot1 = [11,01,10]; idle gaps inside the word must not disturb it.
    prog(1, 0, 3, 3);
    prog(1, 1, 1, 3);
    prog(1, 2, 2, 3);
    send(3); tick(); send(1); tick();
    expect_out("t2.gap", 0, 0, 0, 1);
    send(2); send(0);
    expect_out("t2.slot1", 2, 1, 0, 2);
    send(3); send(1); send(0);
    expect_out("t2.slot0", 1, 1, 0, 3);
    send(3); send(2); send(0);
    expect_out("t2.nomatch", 0, 0, 1, 3);
    tick();
    expect_out("t2.err_drop", 0, 0, 0, 3);

    // Slot2 = slot3 = [10]: multi-hot match counts once.
    prog(2, 0, 2, 1);
    prog(3, 0, 2, 1);
    send(2); send(0);
    expect_out("t3.multi", 12, 1, 0, 4);
    check("t3.cnt2_sat", 32'(wc2), 3);

    // Slot3 = eight 11s, length written as 15 and clamped to 8.
    for (int p = 0; p < 8; p++) prog(3, p, 3, 15);
    for (int i = 0; i < 8; i++) send(3);
    send(0);
    expect_out("t4.maxlen", 8, 1, 0, 5);
    for (int i = 0; i < 9; i++) send(3);
    expect_out("t4.overflow", 0, 0, 0, 5);
    send(0);
    expect_out("t4.reject_close", 0, 0, 1, 5);
    for (int i = 0; i < 3; i++) begin
      send(0);
      expect_out("t4.delims", 0, 0, 0, 5);
    end

    // Saturating counter on the CNT_W=2 instance.
    do_reset();
    expect_out("t5.reset", 0, 0, 0, 0);
    prog(0, 0, 3, 2);
    prog(0, 1, 1, 2);
    for (int i = 1; i <= 5; i++) begin
      send(3); send(1); send(0);
      check("t5.cnt2", 32'(wc2), (i > 3) ? 3 : i);
      check("t5.mv2", 32'(mv2), 1);
      check("t5.cnt", 32'(word_count), i);
    end

    // Config write with a valid symbol mid-word rewrites slot0 to [11,10] and poisons the word.
    send(3);
    cfg_word = 2'd0; cfg_pos = 3'd1; cfg_sym = 2'd2; cfg_len = 4'd2;
    cfg_we = 1'b1; bits = 2'd1; bits_valid = 1'b1;
    tick();
    cfg_we = 1'b0; bits_valid = 1'b0; bits = 2'd0;
    expect_out("t6.cfg_cycle", 0, 0, 0, 5);
    send(0);
    expect_out("t6.aborted", 0, 0, 1, 5);
    send(3); send(1); send(0);
    expect_out("t6.old_pattern", 0, 0, 1, 5);
    send(3); send(2); send(0);
    expect_out("t6.new_pattern", 1, 1, 0, 6);
    check("t6.cnt2", 32'(wc2), 3);

    // Reset mid-word, with a delimiter presented on the reset edge.
    send(3);
    reset = 1'b1; bits = 2'd0; bits_valid = 1'b1;
    tick();
    reset = 1'b0; bits_valid = 1'b0;
    expect_out("t6.reset", 0, 0, 0, 0);
    send(0);
    expect_out("t6.post_reset_delim", 0, 0, 0, 0);
    send(3); send(2); send(0);
    expect_out("t6.patterns_cleared", 0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
